airi5c_ex_hazard_ctrl: RTL and testbench
========================================

Name: airi5c_ex_hazard_ctrl

Overview:
Central sequencing controller for the EX pipeline register stage. It generates the stall, kill and flush controls that gate the DE->EX register update. Causes handled: load-use hazards, multi-cycle unit (PCPI/FPU) waits, writeback backpressure, control-flow redirects, traps and WFI sleep. It sits beside the DE/EX pipeline registers in the core and also exposes a stall-cycle performance counter.

Parameters:
FLUSH_CYCLES, 2, number of cycles killed_de_o/killed_ex_o are held after a redirect or trap; legal range 1..15.
CNT_WIDTH, 32, width of stall_cnt_o.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
de_valid_i  in  1  valid instruction in DE
uses_rs1_de_i / uses_rs2_de_i / uses_rs3_de_i  in  1 each  DE instruction reads rs1/rs2/rs3
rs1_addr_de_i / rs2_addr_de_i / rs3_addr_de_i  in  5 each  DE source register addresses
ex_valid_i  in  1  valid instruction in EX
load_ex_i  in  1  EX instruction is a register-writing load
rd_addr_ex_i  in  5  EX destination register
mc_start_ex_i  in  1  EX instruction uses a multi-cycle unit
mc_ready_i  in  1  multi-cycle result available this cycle
wb_ready_i  in  1  WB stage accepts the EX result
redirect_ex_i  in  1  jump, mispredicted branch or eret resolved in EX
trap_i  in  1  exception or interrupt taken
wfi_ex_i  in  1  EX holds an unkilled WFI
irq_pending_i  in  1  enabled interrupt pending
stall_de_o  out  1  hold DE and fetch
stall_ex_o  out  1  hold the EX pipeline register
killed_de_o  out  1  load a bubble into EX
killed_ex_o  out  1  kill the instruction in EX
flush_o  out  1  single-cycle front-end flush pulse
sleeping_o  out  1  core in WFI sleep
stall_cnt_o  out  CNT_WIDTH  stall-cycle count

Behaviour:
- Reset: state=RUN, flush counter=0, stall_cnt_o=0. All control outputs are combinational from state and inputs; with inputs at 0 they evaluate to 0.
- States: RUN, MC_WAIT, FLUSH, SLEEP.
- Priority within a cycle: trap_i > redirect_ex_i > mc stall > WFI > wb backpressure > load-use.
- Load-use, combinational, RUN only. Hazard = de_valid & ex_valid & load_ex & rd_addr_ex!=0 & any(uses_rsN & rsN_addr==rd_addr_ex). On hazard: stall_de_o=1, killed_de_o=1, stall_ex_o=0. Cost is one bubble.
- Writeback backpressure: in RUN, wb_ready_i=0 forces stall_ex_o=1 and stall_de_o=1. Kills are not asserted.
- Multi-cycle wait:
  - In RUN with ex_valid & mc_start & ~mc_ready: stall_ex_o=stall_de_o=1 in the same cycle; next state is MC_WAIT.
  - In MC_WAIT: stalls held while mc_ready_i=0. The cycle mc_ready_i=1 and wb_ready_i=1, stalls drop and next state is RUN.
  - If mc_ready_i is already 1 in RUN, there is no stall.
- Redirect and trap:
  - Trap is accepted in any state. Redirect is accepted in RUN only when ex_valid_i=1 and wb_ready_i=1.
  - Acceptance cycle: flush_o=1, killed_de_o=1, killed_ex_o=0 for a redirect (the redirecting instruction completes) and killed_ex_o=1 for a trap. Stalls are forced to 0. Counter loads FLUSH_CYCLES-1 and next state is FLUSH.
  - FLUSH: killed_de_o=killed_ex_o=1, stalls=0, counter decrements; exit to RUN when the counter is 0.
  - A new trap or redirect during FLUSH re-pulses flush_o and reloads the counter.
  - A trap in MC_WAIT or SLEEP aborts that state into FLUSH.
- WFI:
  - In RUN with ex_valid & wfi_ex & wb_ready & ~irq_pending: next state is SLEEP.
  - SLEEP: sleeping_o=1, stall_de_o=stall_ex_o=1. When irq_pending_i=1, return to RUN with no stall that cycle; the trap follows from the CSR logic.
  - WFI with irq_pending already set is a NOP and does not enter SLEEP.
- stall_cnt_o increments every cycle where stall_de_o|stall_ex_o=1, including SLEEP. It saturates at all-ones and never wraps.
- Reset mid-operation, in any state, returns immediately to RUN with the counter cleared.

Test Plan:
- Load-use: load in EX with rd=5, DE uses rs2=5 -> exactly one cycle of stall_de_o=1, killed_de_o=1, stall_ex_o=0; same case with rd=0 -> no stall.
- Multi-cycle: mc_start with mc_ready rising after 4 cycles -> stall_ex_o=stall_de_o=1 for 4 cycles, drops in the ready cycle, stall_cnt_o +4.
- Redirect with FLUSH_CYCLES=2 -> flush_o for 1 cycle; killed_de_o for 3 cycles; killed_ex_o=0 in the first cycle, then 1 for 2 cycles; state returns to RUN. Redirect while wb_ready_i=0 -> ignored until wb_ready_i=1.
- Trap in MC_WAIT and a simultaneous redirect+trap -> trap wins, killed_ex_o=1 in the first cycle, MC_WAIT abandoned; second trap during FLUSH reloads the counter.
- WFI with irq_pending_i=0 -> sleeping_o=1 and stalls held 10 cycles; irq_pending_i=1 -> RUN next cycle. WFI with irq_pending_i=1 -> no sleep.
- Counter saturation with CNT_WIDTH=4: 20 stall cycles -> stall_cnt_o=4'hF. rst_ni pulse during SLEEP -> all outputs 0, stall_cnt_o=0.

Source files
------------

// File: rtl/airi5c_ex_hazard_ctrl_if.sv
// rtl/airi5c_ex_hazard_ctrl_if.sv - DE/EX hazard controller signal bundle
interface airi5c_ex_hazard_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 de_valid_i;
    logic                 uses_rs1_de_i;
    logic                 uses_rs2_de_i;
    logic                 uses_rs3_de_i;
    logic [4:0]           rs1_addr_de_i;
    logic [4:0]           rs2_addr_de_i;
    logic [4:0]           rs3_addr_de_i;
    logic                 ex_valid_i;
    logic                 load_ex_i;
    logic [4:0]           rd_addr_ex_i;
    logic                 mc_start_ex_i;
    logic                 mc_ready_i;
    logic                 wb_ready_i;
    logic                 redirect_ex_i;
    logic                 trap_i;
    logic                 wfi_ex_i;
    logic                 irq_pending_i;
    logic                 stall_de_o;
    logic                 stall_ex_o;
    logic                 killed_de_o;
    logic                 killed_ex_o;
    logic                 flush_o;
    logic                 sleeping_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;

    // Pipeline side: drives the hazard inputs, consumes the controls.
    modport master (
        output de_valid_i, uses_rs1_de_i, uses_rs2_de_i, uses_rs3_de_i,
        output rs1_addr_de_i, rs2_addr_de_i, rs3_addr_de_i,
        output ex_valid_i, load_ex_i, rd_addr_ex_i, mc_start_ex_i, mc_ready_i,
        output wb_ready_i, redirect_ex_i, trap_i, wfi_ex_i, irq_pending_i,
        input  stall_de_o, stall_ex_o, killed_de_o, killed_ex_o, flush_o,
        input  sleeping_o, stall_cnt_o
    );

    modport slave (
        input  de_valid_i, uses_rs1_de_i, uses_rs2_de_i, uses_rs3_de_i,
        input  rs1_addr_de_i, rs2_addr_de_i, rs3_addr_de_i,
        input  ex_valid_i, load_ex_i, rd_addr_ex_i, mc_start_ex_i, mc_ready_i,
        input  wb_ready_i, redirect_ex_i, trap_i, wfi_ex_i, irq_pending_i,
        output stall_de_o, stall_ex_o, killed_de_o, killed_ex_o, flush_o,
        output sleeping_o, stall_cnt_o
    );
endinterface

// File: rtl/airi5c_ex_hazard_ctrl.sv
// rtl/airi5c_ex_hazard_ctrl.sv - stall/kill/flush sequencing for the DE->EX register
module airi5c_ex_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    airi5c_ex_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2,
        SLEEP   = 2'd3
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e               state_q, state_d;
    logic [3:0]           flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    logic stall_de, stall_ex, killed_de, killed_ex, flush;
    logic load_use, redirect_ok, mc_block, wfi_sleep, wb_block;

    always_comb begin
        load_use = 1'b0;
        if (bus.de_valid_i && bus.ex_valid_i && bus.load_ex_i && (bus.rd_addr_ex_i != 5'd0)) begin
            load_use = (bus.uses_rs1_de_i && (bus.rs1_addr_de_i == bus.rd_addr_ex_i))
                    || (bus.uses_rs2_de_i && (bus.rs2_addr_de_i == bus.rd_addr_ex_i))
                    || (bus.uses_rs3_de_i && (bus.rs3_addr_de_i == bus.rd_addr_ex_i));
        end
    end

    // A redirect only counts once its instruction can actually retire into WB.
    assign redirect_ok = bus.redirect_ex_i & bus.ex_valid_i & bus.wb_ready_i;
    assign mc_block    = bus.ex_valid_i & bus.mc_start_ex_i & ~bus.mc_ready_i;
    assign wfi_sleep   = bus.ex_valid_i & bus.wfi_ex_i & bus.wb_ready_i & ~bus.irq_pending_i;
    assign wb_block    = bus.ex_valid_i & ~bus.wb_ready_i;

    always_comb begin
        stall_de    = 1'b0;
        stall_ex    = 1'b0;
        killed_de   = 1'b0;
        killed_ex   = 1'b0;
        flush       = 1'b0;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;

        if (bus.trap_i) begin
            flush       = 1'b1;
            killed_de   = 1'b1;
            killed_ex   = 1'b1;
            flush_cnt_d = FLUSH_LOAD;
            state_d     = FLUSH;
        end else begin
            case (state_q)
                RUN: begin
                    if (redirect_ok) begin
                        flush       = 1'b1;
                        killed_de   = 1'b1;
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = FLUSH;
                    end else if (mc_block) begin
                        stall_de = 1'b1;
                        stall_ex = 1'b1;
                        state_d  = MC_WAIT;
                    end else if (wfi_sleep) begin
                        state_d = SLEEP;
                    end else if (wb_block) begin
                        stall_de = 1'b1;
                        stall_ex = 1'b1;
                    end else if (load_use) begin
                        stall_de  = 1'b1;
                        killed_de = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (bus.mc_ready_i && bus.wb_ready_i) begin
                        state_d = RUN;
                    end else begin
                        stall_de = 1'b1;
                        stall_ex = 1'b1;
                    end
                end
                FLUSH: begin
                    killed_de = 1'b1;
                    killed_ex = 1'b1;
                    if (redirect_ok) begin
                        flush       = 1'b1;
                        flush_cnt_d = FLUSH_LOAD;
                    end else if (flush_cnt_q == 4'd0) begin
                        state_d = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end
                end
                SLEEP: begin
                    if (bus.irq_pending_i) begin
                        state_d = RUN;
                    end else begin
                        stall_de = 1'b1;
                        stall_ex = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            // Saturating so long sleeps never read back as a small count.
            if ((stall_de || stall_ex) && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.stall_de_o  = stall_de;
    assign bus.stall_ex_o  = stall_ex;
    assign bus.killed_de_o = killed_de;
    assign bus.killed_ex_o = killed_ex;
    assign bus.flush_o     = flush;
    assign bus.sleeping_o  = (state_q == SLEEP);
    assign bus.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_airi5c_ex_hazard_ctrl.sv
// tb/tb_airi5c_ex_hazard_ctrl.sv - directed and randomized bench for airi5c_ex_hazard_ctrl
module tb_airi5c_ex_hazard_ctrl;
    localparam int FC = 2;
    localparam int CW = 4;
    localparam int M_RUN = 0, M_MC = 1, M_FLUSH = 2, M_SLEEP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    airi5c_ex_hazard_ctrl_if #(.CNT_WIDTH(CW)) bus();

    airi5c_ex_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {stall_de, stall_ex, killed_de, killed_ex, flush, sleeping}
    logic [5:0] dut_v;
    assign dut_v = {bus.stall_de_o, bus.stall_ex_o, bus.killed_de_o,
                    bus.killed_ex_o, bus.flush_o, bus.sleeping_o};

    // Reference model: mode plus number of kill cycles still owed.
    int         m_mode, m_left, m_stalls;
    logic [5:0] m_exp;
    logic       m_redir, m_hazard;
    logic [CW-1:0] m_sat;

    always_comb begin
        m_exp    = 6'b0;
        m_redir  = bus.redirect_ex_i && bus.ex_valid_i && bus.wb_ready_i
                   && (m_mode == M_RUN || m_mode == M_FLUSH);
        m_hazard = 1'b0;
        if (bus.de_valid_i && bus.ex_valid_i && bus.load_ex_i && bus.rd_addr_ex_i != 5'd0) begin
            if (bus.uses_rs1_de_i && bus.rs1_addr_de_i == bus.rd_addr_ex_i) m_hazard = 1'b1;
            if (bus.uses_rs2_de_i && bus.rs2_addr_de_i == bus.rd_addr_ex_i) m_hazard = 1'b1;
            if (bus.uses_rs3_de_i && bus.rs3_addr_de_i == bus.rd_addr_ex_i) m_hazard = 1'b1;
        end
        if (bus.trap_i) m_exp = 6'b001110;
        else if (m_redir) m_exp = (m_mode == M_FLUSH) ? 6'b001110 : 6'b001010;
        else if (m_mode == M_FLUSH) m_exp = 6'b001100;
        else if (m_mode == M_MC) m_exp = (bus.mc_ready_i && bus.wb_ready_i) ? 6'b0 : 6'b110000;
        else if (m_mode == M_SLEEP) m_exp = bus.irq_pending_i ? 6'b0 : 6'b110000;
        else if (bus.ex_valid_i && bus.mc_start_ex_i && !bus.mc_ready_i) m_exp = 6'b110000;
        else if (bus.ex_valid_i && bus.wfi_ex_i && bus.wb_ready_i && !bus.irq_pending_i) m_exp = 6'b0;
        else if (bus.ex_valid_i && !bus.wb_ready_i) m_exp = 6'b110000;
        else if (m_hazard) m_exp = 6'b101000;
        if (m_mode == M_SLEEP) m_exp[0] = 1'b1;
        m_sat = (m_stalls > 15) ? 4'hF : 4'(m_stalls);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode   <= M_RUN;
            m_left   <= 0;
            m_stalls <= 0;
        end else begin
            if (m_exp[5] || m_exp[4]) m_stalls <= m_stalls + 1;
            if (bus.trap_i || m_redir) begin
                m_mode <= M_FLUSH;
                m_left <= FC;
            end else begin
                case (m_mode)
                    M_FLUSH: begin
                        m_left <= m_left - 1;
                        if (m_left == 1) m_mode <= M_RUN;
                    end
                    M_MC:    if (bus.mc_ready_i && bus.wb_ready_i) m_mode <= M_RUN;
                    M_SLEEP: if (bus.irq_pending_i) m_mode <= M_RUN;
                    default: begin
                        if (bus.ex_valid_i && bus.mc_start_ex_i && !bus.mc_ready_i) m_mode <= M_MC;
                        else if (bus.ex_valid_i && bus.wfi_ex_i && bus.wb_ready_i && !bus.irq_pending_i)
                            m_mode <= M_SLEEP;
                    end
                endcase
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle();
        bus.de_valid_i    = 1'b0;
        bus.uses_rs1_de_i = 1'b0;
        bus.uses_rs2_de_i = 1'b0;
        bus.uses_rs3_de_i = 1'b0;
        bus.rs1_addr_de_i = 5'd0;
        bus.rs2_addr_de_i = 5'd0;
        bus.rs3_addr_de_i = 5'd0;
        bus.ex_valid_i    = 1'b0;
        bus.load_ex_i     = 1'b0;
        bus.rd_addr_ex_i  = 5'd0;
        bus.mc_start_ex_i = 1'b0;
        bus.mc_ready_i    = 1'b0;
        bus.wb_ready_i    = 1'b1;
        bus.redirect_ex_i = 1'b0;
        bus.trap_i        = 1'b0;
        bus.wfi_ex_i      = 1'b0;
        bus.irq_pending_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        bus.wb_ready_i = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL reset_outs: got %b expected %b", dut_v, 6'b0); end
        n_cmp++; if (bus.stall_cnt_o !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", bus.stall_cnt_o); end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL post_reset_outs: got %b expected %b", dut_v, 6'b0); end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_valid_i = 1'b1; bus.load_ex_i = 1'b1; bus.rd_addr_ex_i = 5'd5;
        bus.de_valid_i = 1'b1; bus.uses_rs2_de_i = 1'b1; bus.rs2_addr_de_i = 5'd5;
        bus.uses_rs1_de_i = 1'b1; bus.rs1_addr_de_i = 5'd6;
        #1;
        n_cmp++; if (dut_v !== 6'b101000) begin n_err++; $display("FAIL lu_hit: got %b expected %b", dut_v, 6'b101000); end
        tick();
        bus.ex_valid_i = 1'b0; bus.load_ex_i = 1'b0;
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL lu_bubble: got %b expected %b", dut_v, 6'b0); end
        tick();
        bus.ex_valid_i = 1'b1; bus.load_ex_i = 1'b1; bus.rd_addr_ex_i = 5'd0; bus.rs2_addr_de_i = 5'd0;
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL lu_rd0: got %b expected %b", dut_v, 6'b0); end
        tick();
        n_cmp++; if (bus.stall_cnt_o !== 4'd1) begin n_err++; $display("FAIL lu_cnt: got %0d expected 1", bus.stall_cnt_o); end
    endtask

    task automatic test_multicycle();
        do_reset();
        bus.ex_valid_i = 1'b1; bus.mc_start_ex_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.mc_ready_i = (i == 4);
            #1;
            n_cmp++;
            if (dut_v !== ((i < 4) ? 6'b110000 : 6'b0)) begin
                n_err++; $display("FAIL mc_stall[%0d]: got %b expected %b", i, dut_v, (i < 4) ? 6'b110000 : 6'b0);
            end
            tick();
        end
        n_cmp++; if (bus.stall_cnt_o !== 4'd4) begin n_err++; $display("FAIL mc_cnt: got %0d expected 4", bus.stall_cnt_o); end
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL mc_ready_already: got %b expected %b", dut_v, 6'b0); end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        bus.ex_valid_i = 1'b1; bus.redirect_ex_i = 1'b1; bus.wb_ready_i = 1'b0;
        #1;
        n_cmp++; if (dut_v !== 6'b110000) begin n_err++; $display("FAIL redir_wb_blocked: got %b expected %b", dut_v, 6'b110000); end
        tick();
        bus.wb_ready_i = 1'b1;
        #1;
        n_cmp++; if (dut_v !== 6'b001010) begin n_err++; $display("FAIL redir_accept: got %b expected %b", dut_v, 6'b001010); end
        tick();
        bus.redirect_ex_i = 1'b0;
        for (int i = 0; i < FC; i++) begin
            #1;
            n_cmp++; if (dut_v !== 6'b001100) begin n_err++; $display("FAIL redir_flush[%0d]: got %b expected %b", i, dut_v, 6'b001100); end
            tick();
        end
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL redir_done: got %b expected %b", dut_v, 6'b0); end
        tick();
    endtask

    task automatic test_trap();
        do_reset();
        bus.ex_valid_i = 1'b1; bus.mc_start_ex_i = 1'b1;
        tick();
        #1;
        n_cmp++; if (dut_v !== 6'b110000) begin n_err++; $display("FAIL trap_mcwait: got %b expected %b", dut_v, 6'b110000); end
        bus.trap_i = 1'b1; bus.redirect_ex_i = 1'b1;
        #1;
        n_cmp++; if (dut_v !== 6'b001110) begin n_err++; $display("FAIL trap_wins: got %b expected %b", dut_v, 6'b001110); end
        tick();
        bus.trap_i = 1'b0; bus.redirect_ex_i = 1'b0;
        #1;
        n_cmp++; if (dut_v !== 6'b001100) begin n_err++; $display("FAIL trap_flush1: got %b expected %b", dut_v, 6'b001100); end
        bus.trap_i = 1'b1;
        #1;
        n_cmp++; if (dut_v !== 6'b001110) begin n_err++; $display("FAIL trap_refire: got %b expected %b", dut_v, 6'b001110); end
        tick();
        bus.trap_i = 1'b0; bus.ex_valid_i = 1'b0; bus.mc_start_ex_i = 1'b0;
        for (int i = 0; i < FC; i++) begin
            #1;
            n_cmp++; if (dut_v !== 6'b001100) begin n_err++; $display("FAIL trap_reload[%0d]: got %b expected %b", i, dut_v, 6'b001100); end
            tick();
        end
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL trap_done: got %b expected %b", dut_v, 6'b0); end
        tick();
    endtask

    task automatic test_wfi();
        do_reset();
        bus.ex_valid_i = 1'b1; bus.wfi_ex_i = 1'b1;
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL wfi_accept: got %b expected %b", dut_v, 6'b0); end
        tick();
        bus.ex_valid_i = 1'b0; bus.wfi_ex_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++; if (dut_v !== 6'b110001) begin n_err++; $display("FAIL wfi_sleep[%0d]: got %b expected %b", i, dut_v, 6'b110001); end
            tick();
        end
        bus.irq_pending_i = 1'b1;
        #1;
        n_cmp++; if (dut_v !== 6'b000001) begin n_err++; $display("FAIL wfi_wake: got %b expected %b", dut_v, 6'b000001); end
        tick();
        bus.irq_pending_i = 1'b0;
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL wfi_run: got %b expected %b", dut_v, 6'b0); end
        n_cmp++; if (bus.stall_cnt_o !== 4'd10) begin n_err++; $display("FAIL wfi_cnt: got %0d expected 10", bus.stall_cnt_o); end
        bus.ex_valid_i = 1'b1; bus.wfi_ex_i = 1'b1; bus.irq_pending_i = 1'b1;
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL wfi_nop: got %b expected %b", dut_v, 6'b0); end
        tick();
        idle();
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL wfi_nop_nosleep: got %b expected %b", dut_v, 6'b0); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.ex_valid_i = 1'b1; bus.wb_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (bus.stall_cnt_o !== ((i + 1 > 15) ? 4'hF : 4'(i + 1))) begin
                n_err++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, bus.stall_cnt_o, (i + 1 > 15) ? 15 : i + 1);
            end
        end
    endtask

    task automatic test_reset_in_sleep();
        do_reset();
        bus.ex_valid_i = 1'b1; bus.wfi_ex_i = 1'b1;
        tick();
        idle();
        repeat (3) tick();
        n_cmp++; if (dut_v !== 6'b110001) begin n_err++; $display("FAIL rst_sleep_pre: got %b expected %b", dut_v, 6'b110001); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL rst_sleep_outs: got %b expected %b", dut_v, 6'b0); end
        n_cmp++; if (bus.stall_cnt_o !== 4'd0) begin n_err++; $display("FAIL rst_sleep_cnt: got %0d expected 0", bus.stall_cnt_o); end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (dut_v !== 6'b0) begin n_err++; $display("FAIL rst_sleep_after: got %b expected %b", dut_v, 6'b0); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.de_valid_i    = ($urandom_range(0, 99) < 80);
            bus.uses_rs1_de_i = 1'($urandom_range(0, 1));
            bus.uses_rs2_de_i = 1'($urandom_range(0, 1));
            bus.uses_rs3_de_i = ($urandom_range(0, 99) < 20);
            bus.rs1_addr_de_i = 5'($urandom_range(0, 3));
            bus.rs2_addr_de_i = 5'($urandom_range(0, 3));
            bus.rs3_addr_de_i = 5'($urandom_range(0, 3));
            bus.ex_valid_i    = ($urandom_range(0, 99) < 85);
            bus.load_ex_i     = ($urandom_range(0, 99) < 30);
            bus.rd_addr_ex_i  = 5'($urandom_range(0, 3));
            bus.mc_start_ex_i = ($urandom_range(0, 99) < 15);
            bus.mc_ready_i    = ($urandom_range(0, 99) < 35);
            bus.wb_ready_i    = ($urandom_range(0, 99) < 80);
            bus.redirect_ex_i = ($urandom_range(0, 99) < 8);
            bus.trap_i        = ($urandom_range(0, 99) < 3);
            bus.wfi_ex_i      = ($urandom_range(0, 99) < 6);
            bus.irq_pending_i = ($urandom_range(0, 99) < 15);
            #1;
            n_cmp++; if (dut_v !== m_exp) begin n_err++; $display("FAIL rand_outs[%0d]: got %b expected %b", i, dut_v, m_exp); end
            n_cmp++; if (bus.stall_cnt_o !== m_sat) begin n_err++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, bus.stall_cnt_o, m_sat); end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_multicycle();
        test_redirect();
        test_trap();
        test_wfi();
        test_saturation();
        test_reset_in_sleep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
